// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte sources / UART and the shared-transmitter arbiter.
// master = sources plus UART side, slave = arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NREQ = 3
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   txen;
   logic [8*NREQ-1:0] chars;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   busy;
   logic              uart_txen;
   logic [7:0]        uart_char;
   logic              uart_busy;
   logic              timeout;
   logic              drop;

   modport master (
      output req, txen, chars, uart_busy,
      input  gnt, busy, uart_txen, uart_char, timeout, drop
   );

   modport slave (
      input  req, txen, chars, uart_busy,
      output gnt, busy, uart_txen, uart_char, timeout, drop
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter between NREQ sources,
// with an owner-stall watchdog that revokes the grant.
module uart_tx_arbiter #(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic             clk_i,
   input  logic             rst_i,
   uart_tx_arbiter_if.slave bus_io
);
   localparam int unsigned    IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned    WdW    = $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
   localparam logic [WdW-1:0] WdMax  = {WdW{1'b1}};

   typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            pend_q, pend_d;
   logic [WdW-1:0]  wdog_q, wdog_d;
   logic            uart_txen_q, uart_txen_d;
   logic [7:0]      uart_char_q, uart_char_d;
   logic            timeout_q, timeout_d;
   logic            drop_q, drop_d;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] txen;
   logic [NREQ-1:0] busy;
   logic            uart_busy;
   logic [7:0]      owner_char;
   logic            owner_txen;
   logic            fwd;
   logic            pick_vld;
   logic [IdxW-1:0] pick_idx;

   assign req        = bus_io.req;
   assign txen       = bus_io.txen;
   assign uart_busy  = bus_io.uart_busy;
   assign busy       = ~gnt_q | {NREQ{pend_q | uart_busy}};
   assign owner_char = bus_io.chars[8*32'(ptr_q) +: 8];
   assign owner_txen = txen[ptr_q];
   assign fwd        = (state_q == StGrant) && owner_txen && !busy[ptr_q];

   // Rotating scan starting just after the last owner gives round-robin fairness.
   always_comb begin
      int unsigned cand;
      cand     = 0;
      pick_vld = 1'b0;
      pick_idx = ptr_q;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = (32'(ptr_q) + i) % NREQ;
         if (!pick_vld && req[IdxW'(cand)]) begin
            pick_vld = 1'b1;
            pick_idx = IdxW'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
      pend_d      = pend_q;
      wdog_d      = wdog_q;
      uart_txen_d = 1'b0;
      uart_char_d = uart_char_q;
      timeout_d   = 1'b0;
      drop_d      = |(txen & ~(fwd ? gnt_q : '0));

      // pend bridges the gap until the UART raises its own busy.
      if (fwd) begin
         pend_d = 1'b1;
      end else if (uart_busy) begin
         pend_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (pick_vld) begin
               gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
               ptr_d   = pick_idx;
               wdog_d  = '0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (fwd) begin
               uart_txen_d = 1'b1;
               uart_char_d = owner_char;
               wdog_d      = '0;
            end else if (wdog_q != WdMax) begin
               wdog_d = wdog_q + WdW'(1);
            end
            if (!req[ptr_q]) begin
               gnt_d   = '0;
               state_d = StDrain;
            end else if (wdog_q == WdLast && !owner_txen) begin
               timeout_d = 1'b1;
               gnt_d     = '0;
               state_d   = StDrain;
            end
         end
         StDrain: begin
            if (!pend_q && !uart_busy) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         gnt_q       <= '0;
         ptr_q       <= IdxW'(NREQ - 1);
         pend_q      <= 1'b0;
         wdog_q      <= '0;
         uart_txen_q <= 1'b0;
         uart_char_q <= '0;
         timeout_q   <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ptr_q       <= ptr_d;
         pend_q      <= pend_d;
         wdog_q      <= wdog_d;
         uart_txen_q <= uart_txen_d;
         uart_char_q <= uart_char_d;
         timeout_q   <= timeout_d;
         drop_q      <= drop_d;
      end
   end

   assign bus_io.gnt       = gnt_q;
   assign bus_io.busy      = busy;
   assign bus_io.uart_txen = uart_txen_q;
   assign bus_io.uart_char = uart_char_q;
   assign bus_io.timeout   = timeout_q;
   assign bus_io.drop      = drop_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one DUT with a 10-cycle UART model, a second
// DUT with TIMEOUT=8 for the watchdog.
module tb_uart_tx_arbiter;
   localparam int unsigned N = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   ucnt = 0;
   int   n_pulse = 0;
   int   n_overlap = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NREQ(N)) bus ();
   uart_tx_arbiter_if #(.NREQ(N)) bus_wd ();

   uart_tx_arbiter #(.NREQ(N), .TIMEOUT(64)) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   uart_tx_arbiter #(.NREQ(N), .TIMEOUT(8)) u_dut_wd (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus_wd)
   );

   // UART stand-in: busy for 10 cycles after each strobe
   always @(posedge clk) begin
      if (bus.uart_txen) ucnt <= 10;
      else if (ucnt != 0) ucnt <= ucnt - 1;
   end
   assign bus.uart_busy    = (ucnt != 0);
   assign bus_wd.uart_busy = 1'b0;

   always @(posedge clk) if (bus.uart_txen) n_pulse <= n_pulse + 1;
   always @(negedge clk) if (!$onehot0(bus.gnt)) n_overlap <= n_overlap + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1;
      bus.req = '0; bus.txen = '0; bus.chars = '0;
      bus_wd.req = '0; bus_wd.txen = '0; bus_wd.chars = '0;
      repeat (2) tick();
      n = 0;
      while (ucnt != 0 && n < 50) begin tick(); n++; end
      rst = 1'b0;
      tick();
   endtask

   task automatic send(input int s, input logic [7:0] c);
      int n;
      n = 0;
      while (bus.busy[s] && n < 200) begin tick(); n++; end
      if (n >= 200) check_val("send_wait", 32'd1, 32'd0);
      bus.txen[s] = 1'b1;
      bus.chars[8*s +: 8] = c;
      tick();
      bus.txen[s] = 1'b0;
      check_val("fwd_txen", bus.uart_txen, 32'd1);
      check_val("fwd_char", bus.uart_char, c);
   endtask

   task automatic wait_gnt(input string tag, input logic [N-1:0] exp);
      int n;
      n = 0;
      while (bus.gnt == '0 && n < 100) begin tick(); n++; end
      check_val(tag, bus.gnt, exp);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.uart_busy && n < 100) begin tick(); n++; end
      repeat (3) tick();
   endtask

   initial begin
      int p0;
      int bad;
      bus.req = '0; bus.txen = '0; bus.chars = '0;
      bus_wd.req = '0; bus_wd.txen = '0; bus_wd.chars = '0;
      #2;
      check_val("rst_gnt", bus.gnt, 32'd0);
      check_val("rst_busy", bus.busy, 32'h7);
      check_val("rst_uart_txen", bus.uart_txen, 32'd0);
      check_val("rst_uart_char", bus.uart_char, 32'd0);
      check_val("rst_timeout", bus.timeout, 32'd0);
      check_val("rst_drop", bus.drop, 32'd0);
      do_reset();

      // single source, three bytes
      p0 = n_pulse;
      bus.req = 3'b001;
      tick();
      check_val("t1_gnt", bus.gnt, 32'h1);
      send(0, 8'h50);
      check_val("t1_busy12", bus.busy[2:1], 32'h3);
      check_val("t1_busy0", bus.busy[0], 32'd1);
      send(0, 8'h30);
      send(0, 8'h2C);
      bus.req = '0;
      tick();
      check_val("t1_release", bus.gnt, 32'd0);
      wait_idle();
      check_val("t1_pulses", n_pulse - p0, 32'd3);

      // three-way round robin
      do_reset();
      bus.req = 3'b111;
      tick();
      check_val("t2_gnt0", bus.gnt, 32'h1);
      send(0, 8'h41);
      bus.req[0] = 1'b0;
      tick();
      check_val("t2_drain", bus.gnt, 32'd0);
      wait_gnt("t2_gnt1", 3'b010);
      send(1, 8'h42);
      bus.req[1] = 1'b0;
      tick();
      wait_gnt("t2_gnt2", 3'b100);
      send(2, 8'h43);
      bus.req = 3'b000;
      tick();
      bus.req = 3'b111;
      wait_gnt("t2_round2", 3'b001);
      bus.req = '0;
      wait_idle();

      // release during UART busy, DRAIN holds
      do_reset();
      bus.req = 3'b010;
      tick();
      check_val("t3_gnt1", bus.gnt, 32'h2);
      send(1, 8'h58);
      tick();
      check_val("t3_ubusy", bus.uart_busy, 32'd1);
      bus.req = 3'b100;
      tick();
      check_val("t3_drain", bus.gnt, 32'd0);
      bad = 0;
      for (int i = 0; i < 50 && bus.uart_busy; i++) begin
         if (bus.gnt != '0) bad++;
         tick();
      end
      check_val("t3_hold", bad, 32'd0);
      check_val("t3_ubusy_done", bus.uart_busy, 32'd0);
      tick();
      check_val("t3_idle", bus.gnt, 32'd0);
      tick();
      check_val("t3_gnt2", bus.gnt, 32'h4);
      bus.req = '0;
      wait_idle();

      // watchdog, TIMEOUT=8
      do_reset();
      bus_wd.req = 3'b011;
      tick();
      check_val("t4_gnt0", bus_wd.gnt, 32'h1);
      repeat (7) tick();
      check_val("t4_pre_to", bus_wd.timeout, 32'd0);
      check_val("t4_pre_gnt", bus_wd.gnt, 32'h1);
      tick();
      check_val("t4_timeout", bus_wd.timeout, 32'd1);
      check_val("t4_revoke", bus_wd.gnt, 32'd0);
      tick();
      check_val("t4_pulse_end", bus_wd.timeout, 32'd0);
      check_val("t4_idle", bus_wd.gnt, 32'd0);
      tick();
      check_val("t4_gnt1", bus_wd.gnt, 32'h2);
      bus_wd.req = '0;

      // drops: non-owner txen, owner txen while busy
      do_reset();
      bus.req = 3'b001;
      tick();
      check_val("t5_gnt", bus.gnt, 32'h1);
      bus.txen = 3'b100;
      bus.chars[23:16] = 8'h55;
      tick();
      bus.txen = '0;
      check_val("t5_nonown_txen", bus.uart_txen, 32'd0);
      check_val("t5_nonown_drop", bus.drop, 32'd1);
      tick();
      check_val("t5_drop_end", bus.drop, 32'd0);
      send(0, 8'h51);
      check_val("t5_busy0", bus.busy[0], 32'd1);
      bus.txen[0] = 1'b1;
      bus.chars[7:0] = 8'h52;
      tick();
      bus.txen = '0;
      check_val("t5_busy_txen", bus.uart_txen, 32'd0);
      check_val("t5_busy_drop", bus.drop, 32'd1);
      check_val("t5_char_hold", bus.uart_char, 32'h51);
      bus.req = '0;
      wait_idle();

      // asynchronous reset mid-packet
      do_reset();
      bus.req = 3'b010;
      tick();
      check_val("t6_gnt", bus.gnt, 32'h2);
      send(1, 8'h52);
      #2 rst = 1'b1;
      #1;
      check_val("t6_gnt_clr", bus.gnt, 32'd0);
      check_val("t6_busy_set", bus.busy, 32'h7);
      check_val("t6_txen_clr", bus.uart_txen, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check_val("t6_regrant", bus.gnt, 32'h2);
      bus.req = '0;
      wait_idle();

      check_val("gnt_onehot", n_overlap, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
